dispatch_ctrl: RTL and testbench
================================

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 rdy  in  1  global enable; when 0 the block freezes.
REQ-004 flush  in  1  mispredict squash of all in-flight instructions.
REQ-005 dec_en  in  1  decoder presents a valid decoded instruction this cycle.
REQ-006 dec_cls  in  2  instruction class: 00 ALU/branch/jump → RS; 01 load → LSB; 10 store → LSB; 11 NOP → discard.
REQ-007 rob_commit  in  1  one ROB entry retired this cycle.
REQ-008 rs_release  in  1  one RS slot freed this cycle.
REQ-009 lsb_release  in  1  one LSB slot freed this cycle.
REQ-010 stall  out  1  fetch/decode must not present dec_en next; combinational from registers only.
REQ-011 rob_en  out  1  allocate ROB entry; one-cycle pulse.
REQ-012 rob_tag  out  4  ROB index allocated with rob_en.
REQ-013 rs_en  out  1  write RS slot; one-cycle pulse.
REQ-014 lsb_en  out  1  write LSB slot; one-cycle pulse.
REQ-015 err  out  1  sticky protocol-violation flag.

Function
REQ-016 Capacities SHALL be fixed: ROB 16, RS 16, LSB 16; free-credit counters rob_cr, rs_cr, lsb_cr are 5 bits each, range 0..16.
REQ-017 States SHALL be RUN, HOLD, RECOVER; stall = (state==HOLD) | (state==RECOVER).
REQ-018 Candidate SHALL be the hold buffer {cls} in HOLD, else dec_en/dec_cls in RUN; no candidate in RECOVER.
REQ-019 A class 00 candidate dispatches iff rob_cr>0 and rs_cr>0; class 01/10 iff rob_cr>0 and lsb_cr>0; class 11 always retires silently with no enable pulse and no credit change.
REQ-020 On dispatch, next cycle rob_en=1, rob_tag=tail, rs_en or lsb_en=1 per class; tail increments mod 16 (15→0); rob_cr and the target credit decrement by 1. Latency: exactly one cycle from candidate to enables.
REQ-021 Enable outputs SHALL be 0 in every cycle not following a dispatch.
REQ-022 RUN, candidate present but blocked: capture dec_cls into hold buffer, go HOLD. HOLD, candidate dispatches: go RUN; else stay HOLD.
REQ-023 Each release input SHALL add 1 to its counter in the same cycle; simultaneous dispatch and release on the same counter nets to no change.
REQ-024 A release that would take a counter above 16 SHALL saturate at 16 and set err.
REQ-025 dec_en=1 while stall=1 SHALL be ignored (instruction dropped) and set err.
REQ-026 flush (with rdy=1) SHALL take priority over all other events: clear hold buffer, set all credits to 16, tail to 0, enables 0 next cycle, go RECOVER; releases and dec_en in that cycle ignored (no err).
REQ-027 RECOVER SHALL last exactly one cycle, then RUN; flush in RECOVER re-enters RECOVER.
REQ-028 rdy=0: all state, counters, tail, err hold; enables driven 0 next cycle; all inputs including flush ignored.

Reset
REQ-029 rst=1 at a clock edge SHALL force: state RUN, hold buffer empty, rob_cr=rs_cr=lsb_cr=16, tail=0, rob_en=rs_en=lsb_en=0, rob_tag=0, err=0; rst overrides rdy and flush, and aborts any in-progress HOLD.

Verification
REQ-030 After reset, dec_en with cls 00,01,10 on three consecutive cycles → rob_en each following cycle with rob_tag 0,1,2; rs_en,lsb_en,lsb_en; rob_cr=13.
REQ-031 17 class-00 dispatches, no releases → first 16 issue (tags 0..15), 17th enters HOLD, stall=1; one rob_commit+rs_release → issues tag 0 next cycle, returns to RUN.
REQ-032 Class 11 candidate → no enables, credits unchanged, tail unchanged.
REQ-033 In HOLD with rob_cr=0, assert flush → next cycle enables 0, stall=1 (RECOVER), credits 16, tail 0; following cycle stall=0; next dispatch gets rob_tag 0.
REQ-034 rs_release with rs_cr=16 → rs_cr stays 16, err=1; dec_en during stall → no dispatch, err=1.
REQ-035 rdy=0 for 3 cycles with dec_en=1 and flush=1 → no enables, state/counters unchanged; rdy=1 resumes from identical state.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: steers decoded instructions into ROB + RS/LSB using
// free-credit counters, with a one-entry hold buffer for blocked instructions
// and a one-cycle recovery window after a mispredict flush.
module dispatch_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       flush,
  input  logic       dec_en,
  input  logic [1:0] dec_cls,
  input  logic       rob_commit,
  input  logic       rs_release,
  input  logic       lsb_release,
  output logic       stall,
  output logic       rob_en,
  output logic [3:0] rob_tag,
  output logic       rs_en,
  output logic       lsb_en,
  output logic       err
);

  localparam logic [4:0] CAP = 5'd16;

  typedef enum logic [1:0] {RUN, HOLD, RECOVER} state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_hold_cls, w_hold_nxt;
  logic [4:0] r_rob_cr, r_rs_cr, r_lsb_cr;
  logic [4:0] w_rob_cr_nxt, w_rs_cr_nxt, w_lsb_cr_nxt;
  logic [3:0] r_tail, w_tail_nxt;
  logic [3:0] r_rob_tag, w_tag_nxt;
  logic       r_rob_en, r_rs_en, r_lsb_en, r_err;
  logic       w_rob_en_nxt, w_rs_en_nxt, w_lsb_en_nxt, w_err_nxt;

  logic       w_cand_vld, w_is_rs, w_is_lsb, w_is_nop, w_ok, w_disp;
  logic       w_ovf_rob, w_ovf_rs, w_ovf_lsb;

  // Candidate selection and resource check against current credits
  always_comb begin
    w_cand_vld = (r_state == HOLD) | ((r_state == RUN) & dec_en);
    w_is_rs    = 1'b0;
    w_is_lsb   = 1'b0;
    w_is_nop   = 1'b0;
    case ((r_state == HOLD) ? r_hold_cls : dec_cls)
      2'b00:   w_is_rs  = 1'b1;
      2'b01,
      2'b10:   w_is_lsb = 1'b1;
      default: w_is_nop = 1'b1;
    endcase
    w_ok   = w_is_nop | ((r_rob_cr != 5'd0) &
             (w_is_rs ? (r_rs_cr != 5'd0) : (r_lsb_cr != 5'd0)));
    w_disp = rdy & ~flush & w_cand_vld & ~w_is_nop & w_ok;
    // A release with no matching dispatch on a full counter overflows
    w_ovf_rob = rob_commit  & ~w_disp             & (r_rob_cr == CAP);
    w_ovf_rs  = rs_release  & ~(w_disp & w_is_rs)  & (r_rs_cr  == CAP);
    w_ovf_lsb = lsb_release & ~(w_disp & w_is_lsb) & (r_lsb_cr == CAP);
  end

  // Next-state, credit, tail and output-pulse logic
  always_comb begin
    w_state_nxt  = r_state;
    w_hold_nxt   = r_hold_cls;
    w_rob_cr_nxt = r_rob_cr;
    w_rs_cr_nxt  = r_rs_cr;
    w_lsb_cr_nxt = r_lsb_cr;
    w_tail_nxt   = r_tail;
    w_tag_nxt    = r_rob_tag;
    w_rob_en_nxt = 1'b0;
    w_rs_en_nxt  = 1'b0;
    w_lsb_en_nxt = 1'b0;
    w_err_nxt    = r_err;
    if (!rdy) begin
      // frozen: everything holds, pulses drop
    end else if (flush) begin
      w_state_nxt  = RECOVER;
      w_hold_nxt   = 2'b00;
      w_rob_cr_nxt = CAP;
      w_rs_cr_nxt  = CAP;
      w_lsb_cr_nxt = CAP;
      w_tail_nxt   = 4'd0;
    end else begin
      case (r_state)
        RUN:     if (w_cand_vld && !w_ok) begin
                   w_state_nxt = HOLD;
                   w_hold_nxt  = dec_cls;
                 end
        HOLD:    if (w_ok) w_state_nxt = RUN;
        default: w_state_nxt = RUN;
      endcase
      if (w_disp) begin
        w_rob_en_nxt = 1'b1;
        w_rs_en_nxt  = w_is_rs;
        w_lsb_en_nxt = w_is_lsb;
        w_tag_nxt    = r_tail;
        w_tail_nxt   = r_tail + 4'd1;
      end
      w_rob_cr_nxt = w_ovf_rob ? CAP :
                     r_rob_cr - 5'(w_disp) + 5'(rob_commit);
      w_rs_cr_nxt  = w_ovf_rs ? CAP :
                     r_rs_cr - 5'(w_disp & w_is_rs) + 5'(rs_release);
      w_lsb_cr_nxt = w_ovf_lsb ? CAP :
                     r_lsb_cr - 5'(w_disp & w_is_lsb) + 5'(lsb_release);
      if (w_ovf_rob | w_ovf_rs | w_ovf_lsb | (dec_en & stall))
        w_err_nxt = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // Datapath registers: hold buffer, credits, tail, output pulses, err
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cls <= 2'b00;
      r_rob_cr   <= CAP;
      r_rs_cr    <= CAP;
      r_lsb_cr   <= CAP;
      r_tail     <= 4'd0;
      r_rob_tag  <= 4'd0;
      r_rob_en   <= 1'b0;
      r_rs_en    <= 1'b0;
      r_lsb_en   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_hold_cls <= w_hold_nxt;
      r_rob_cr   <= w_rob_cr_nxt;
      r_rs_cr    <= w_rs_cr_nxt;
      r_lsb_cr   <= w_lsb_cr_nxt;
      r_tail     <= w_tail_nxt;
      r_rob_tag  <= w_tag_nxt;
      r_rob_en   <= w_rob_en_nxt;
      r_rs_en    <= w_rs_en_nxt;
      r_lsb_en   <= w_lsb_en_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign stall   = (r_state == HOLD) | (r_state == RECOVER);
  assign rob_en  = r_rob_en;
  assign rob_tag = r_rob_tag;
  assign rs_en   = r_rs_en;
  assign lsb_en  = r_lsb_en;
  assign err     = r_err;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: hand-computed expectations per scenario.
module tb_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst, rdy, flush, dec_en, rob_commit, rs_release, lsb_release;
  logic [1:0] dec_cls;
  logic       stall, rob_en, rs_en, lsb_en, err;
  logic [3:0] rob_tag;

  int n_chk = 0;
  int n_err = 0;

  dispatch_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .dec_en(dec_en),
    .dec_cls(dec_cls), .rob_commit(rob_commit), .rs_release(rs_release),
    .lsb_release(lsb_release), .stall(stall), .rob_en(rob_en),
    .rob_tag(rob_tag), .rs_en(rs_en), .lsb_en(lsb_en), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one clock; outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; dec_en = 1'b0; dec_cls = 2'b00;
    rob_commit = 1'b0; rs_release = 1'b0; lsb_release = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic chk_en(input string tag, input int e_rob, input int e_rs, input int e_lsb);
    chk({tag, "_rob_en"}, 32'(rob_en), e_rob);
    chk({tag, "_rs_en"},  32'(rs_en),  e_rs);
    chk({tag, "_lsb_en"}, 32'(lsb_en), e_lsb);
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_stall", 32'(stall), 0);
    chk_en("rst", 0, 0, 0);
    chk("rst_tag", 32'(rob_tag), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_robcr", 32'(dut.r_rob_cr), 16);

    // three consecutive dispatches of classes 00, 01, 10
    dec_en = 1'b1; dec_cls = 2'b00; tick();
    chk_en("c00", 1, 1, 0); chk("c00_tag", 32'(rob_tag), 0);
    dec_cls = 2'b01; tick();
    chk_en("c01", 1, 0, 1); chk("c01_tag", 32'(rob_tag), 1);
    dec_cls = 2'b10; tick();
    chk_en("c10", 1, 0, 1); chk("c10_tag", 32'(rob_tag), 2);
    dec_en = 1'b0; tick();
    chk_en("idle", 0, 0, 0);
    chk("robcr13", 32'(dut.r_rob_cr), 13);
    chk("rscr15", 32'(dut.r_rs_cr), 15);
    chk("lsbcr14", 32'(dut.r_lsb_cr), 14);

    // class 11 retires silently
    do_reset();
    dec_en = 1'b1; dec_cls = 2'b11; tick();
    chk_en("nop", 0, 0, 0);
    chk("nop_stall", 32'(stall), 0);
    chk("nop_robcr", 32'(dut.r_rob_cr), 16);
    dec_cls = 2'b00; tick();
    chk("nop_tail", 32'(rob_tag), 0);
    chk("nop_rob_en", 32'(rob_en), 1);
    dec_en = 1'b0;

    // fill ROB with 16 class-00 dispatches, 17th blocks
    do_reset();
    dec_en = 1'b1; dec_cls = 2'b00;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("fill_en", 32'(rob_en), 1);
      chk("fill_tag", 32'(rob_tag), 32'(i));
    end
    tick();
    chk("blk_rob_en", 32'(rob_en), 0);
    chk("blk_stall", 32'(stall), 1);
    chk("blk_err0", 32'(err), 0);
    // dec_en while stalled is dropped and flags err
    dec_cls = 2'b01; tick();
    chk_en("drop", 0, 0, 0);
    chk("drop_err", 32'(err), 1);
    dec_en = 1'b0;
    // free one ROB + one RS slot; held instruction issues on the next edge
    rob_commit = 1'b1; rs_release = 1'b1; tick();
    rob_commit = 1'b0; rs_release = 1'b0;
    chk("rel_stall", 32'(stall), 1);
    chk("rel_rob_en", 32'(rob_en), 0);
    tick();
    chk_en("reissue", 1, 1, 0);
    chk("reissue_tag", 32'(rob_tag), 0);
    chk("reissue_stall", 32'(stall), 0);

    // block again (rob_cr=0), then flush out of HOLD
    dec_en = 1'b1; dec_cls = 2'b00; tick();
    dec_en = 1'b0;
    chk("hold2_stall", 32'(stall), 1);
    flush = 1'b1; tick();
    flush = 1'b0;
    chk_en("flush", 0, 0, 0);
    chk("flush_stall", 32'(stall), 1);
    chk("flush_robcr", 32'(dut.r_rob_cr), 16);
    chk("flush_rscr", 32'(dut.r_rs_cr), 16);
    chk("flush_tail", 32'(dut.r_tail), 0);
    tick();
    chk("recov_stall", 32'(stall), 0);
    dec_en = 1'b1; dec_cls = 2'b01; tick();
    dec_en = 1'b0;
    chk_en("postflush", 1, 0, 1);
    chk("postflush_tag", 32'(rob_tag), 0);

    // release on a full counter saturates and flags err
    do_reset();
    chk("sat_err0", 32'(err), 0);
    rs_release = 1'b1; tick();
    rs_release = 1'b0;
    chk("sat_rscr", 32'(dut.r_rs_cr), 16);
    chk("sat_err", 32'(err), 1);

    // rdy=0 freezes everything and ignores dec_en/flush
    do_reset();
    dec_en = 1'b1; dec_cls = 2'b00; tick();
    chk("pre_frz_tag", 32'(rob_tag), 0);
    rdy = 1'b0; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_en("frz", 0, 0, 0);
      chk("frz_stall", 32'(stall), 0);
    end
    chk("frz_robcr", 32'(dut.r_rob_cr), 15);
    chk("frz_tail", 32'(dut.r_tail), 1);
    rdy = 1'b1; flush = 1'b0; tick();
    dec_en = 1'b0;
    chk_en("resume", 1, 1, 0);
    chk("resume_tag", 32'(rob_tag), 1);
    chk("resume_err", 32'(err), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
